// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//
// Elastic pipeline-stage register with a 2-entry skid buffer. It replaces a
// fixed stage-boundary latch (for example MEM->WB) with valid/ready handshakes
// on both sides. The skid entry breaks the combinational path from
// OUT_READY back to IN_READY.
//
// Only a slice of the incoming control bundle is forwarded:
//     IN_CTRL[CTRL_LSB +: CTRL_OUT_W]
// A flush empties the stage and presents a bubble (OUT_CTRL = 0).
// Cycles where the output is held because the downstream is not ready are
// counted in a saturating counter.
//
// Ports
//   CLK        : rising-edge clock
//   RESET_N    : asynchronous active-low reset
//   FLUSH      : synchronous flush, discards every held beat
//   IN_VALID   : upstream beat valid
//   IN_READY   : stage can accept a beat this cycle
//   IN_CTRL    : upstream control bundle (CTRL_IN_W bits)
//   IN_DATA    : upstream payload (DATA_W bits)
//   OUT_VALID  : head beat valid
//   OUT_READY  : downstream accepts the head beat
//   OUT_CTRL   : forwarded control slice of the head beat, zero when empty
//   OUT_DATA   : payload of the head beat, holds its last value when empty
//   OCCUPANCY  : number of held beats (0..2)
//   STALL_CNT  : saturating count of cycles with OUT_VALID & ~OUT_READY
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int DATA_W     = 32,
    parameter int CTRL_IN_W  = 5,
    parameter int CTRL_OUT_W = 2,
    parameter int CTRL_LSB   = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  FLUSH,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [CTRL_IN_W-1:0]  IN_CTRL,
    input  logic [DATA_W-1:0]     IN_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [CTRL_OUT_W-1:0] OUT_CTRL,
    output logic [DATA_W-1:0]     OUT_DATA,
    output logic [1:0]            OCCUPANCY,
    output logic [CNT_W-1:0]      STALL_CNT
);

    // The forwarded slice must fit inside the incoming bundle.
    generate
        if ((CTRL_LSB + CTRL_OUT_W) > CTRL_IN_W) begin : g_bad_ctrl_slice
            $error("pipe_skid_reg: CTRL_LSB + CTRL_OUT_W exceeds CTRL_IN_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Saturating increment used by the stall counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    out_valid_r;
    logic [CTRL_OUT_W-1:0]   main_ctrl_r;
    logic [DATA_W-1:0]       main_data_r;
    logic [CTRL_OUT_W-1:0]   skid_ctrl_r;
    logic [DATA_W-1:0]       skid_data_r;
    logic [CNT_W-1:0]        stall_cnt_r;

    logic                    in_ready_s;
    logic                    accept_s;
    logic                    emit_s;
    logic                    load_main_in_s;
    logic                    load_main_skid_s;
    logic                    load_skid_in_s;
    logic [CTRL_OUT_W-1:0]   in_slice_s;
    logic                    unused_ctrl_s;

    // Control bits outside the forwarded slice are intentionally dropped here.
    assign unused_ctrl_s = ^IN_CTRL;
    assign in_slice_s    = IN_CTRL[CTRL_LSB +: CTRL_OUT_W];

    // Ready depends only on registered occupancy, FLUSH and RESET_N.
    // It never depends on OUT_READY, so no path crosses the stage.
    assign in_ready_s = RESET_N & ~FLUSH & (state_r != ST_TWO);
    assign accept_s   = IN_VALID & in_ready_s;
    assign emit_s     = out_valid_r & OUT_READY;

    // Occupancy state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; flush overrides every other event.
    always_comb begin
        state_next_s = state_r;
        if (FLUSH) begin
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_next_s = ST_ONE;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && !emit_s) begin
                        state_next_s = ST_TWO;
                    end else if (emit_s && !accept_s) begin
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (emit_s) begin
                        state_next_s = ST_ONE;
                    end else begin
                        state_next_s = ST_TWO;
                    end
                end
                default: begin
                    state_next_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Entry load strobes for each state transition.
    always_comb begin
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_in_s   = 1'b0;
        if (FLUSH) begin
            load_main_in_s   = 1'b0;
            load_main_skid_s = 1'b0;
            load_skid_in_s   = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    load_main_in_s = accept_s;
                end
                ST_ONE: begin
                    load_main_in_s = accept_s & emit_s;
                    load_skid_in_s = accept_s & ~emit_s;
                end
                ST_TWO: begin
                    load_main_skid_s = emit_s;
                end
                default: begin
                    load_main_in_s   = 1'b0;
                    load_main_skid_s = 1'b0;
                    load_skid_in_s   = 1'b0;
                end
            endcase
        end
    end

    // Main entry drives OUT_*; an empty stage always presents a zero-control bubble.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid_r <= 1'b0;
            main_ctrl_r <= {CTRL_OUT_W{1'b0}};
            main_data_r <= {DATA_W{1'b0}};
        end else begin
            out_valid_r <= (state_next_s != ST_EMPTY);
            if (state_next_s == ST_EMPTY) begin
                // Payload is left as-is; only the control slice becomes a bubble.
                main_ctrl_r <= {CTRL_OUT_W{1'b0}};
            end else if (load_main_in_s) begin
                main_ctrl_r <= in_slice_s;
                main_data_r <= IN_DATA;
            end else if (load_main_skid_s) begin
                main_ctrl_r <= skid_ctrl_r;
                main_data_r <= skid_data_r;
            end else begin
                main_ctrl_r <= main_ctrl_r;
                main_data_r <= main_data_r;
            end
        end
    end

    // Skid entry absorbs the one beat that arrives after back-pressure starts.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            skid_ctrl_r <= {CTRL_OUT_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
        end else if (load_skid_in_s) begin
            skid_ctrl_r <= in_slice_s;
            skid_data_r <= IN_DATA;
        end else begin
            skid_ctrl_r <= skid_ctrl_r;
            skid_data_r <= skid_data_r;
        end
    end

    // Stall counter, saturating, cleared only by reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && !OUT_READY) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign IN_READY  = in_ready_s;
    assign OUT_VALID = out_valid_r;
    assign OUT_CTRL  = main_ctrl_r;
    assign OUT_DATA  = main_data_r;
    assign OCCUPANCY = state_r;
    assign STALL_CNT = stall_cnt_r;

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    logic        CLK;
    logic        RESET_N;
    logic        FLUSH;
    logic        IN_VALID;
    logic        IN_READY;
    logic [4:0]  IN_CTRL;
    logic [31:0] IN_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [1:0]  OUT_CTRL;
    logic [31:0] OUT_DATA;
    logic [1:0]  OCCUPANCY;
    logic [3:0]  STALL_CNT;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        flush;
        logic        iv;
        logic [4:0]  ictrl;
        logic [31:0] idata;
        logic        ordy;
        logic        e_ird;
        logic        e_ov;
        logic [1:0]  e_octrl;
        logic [31:0] e_odata;
        logic [1:0]  e_occ;
        logic [3:0]  e_stall;
    } vec_t;

    vec_t vecs [19];

    pipe_skid_reg #(
        .DATA_W     (32),
        .CTRL_IN_W  (5),
        .CTRL_OUT_W (2),
        .CTRL_LSB   (3),
        .CNT_W      (4)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_CTRL   (IN_CTRL),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_CTRL  (OUT_CTRL),
        .OUT_DATA  (OUT_DATA),
        .OCCUPANCY (OCCUPANCY),
        .STALL_CNT (STALL_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".ov"},    {31'd0, OUT_VALID}, 32'd0);
        chk({tag, ".octrl"}, {30'd0, OUT_CTRL},  32'd0);
        chk({tag, ".odata"}, OUT_DATA,           32'd0);
        chk({tag, ".occ"},   {30'd0, OCCUPANCY}, 32'd0);
        chk({tag, ".stall"}, {28'd0, STALL_CNT}, 32'd0);
    endtask

    // Drive a vector at the falling edge, check IN_READY before the rising edge,
    // then check registered outputs just after it.
    task automatic step(input vec_t v, input string tag);
        @(negedge CLK);
        FLUSH     = v.flush;
        IN_VALID  = v.iv;
        IN_CTRL   = v.ictrl;
        IN_DATA   = v.idata;
        OUT_READY = v.ordy;
        #1;
        chk({tag, ".ird"}, {31'd0, IN_READY}, {31'd0, v.e_ird});
        @(posedge CLK);
        #1;
        chk({tag, ".ov"},    {31'd0, OUT_VALID}, {31'd0, v.e_ov});
        chk({tag, ".octrl"}, {30'd0, OUT_CTRL},  {30'd0, v.e_octrl});
        chk({tag, ".odata"}, OUT_DATA,           v.e_odata);
        chk({tag, ".occ"},   {30'd0, OCCUPANCY}, {30'd0, v.e_occ});
        chk({tag, ".stall"}, {28'd0, STALL_CNT}, {28'd0, v.e_stall});
    endtask

    // Pulse reset low between edges and check both the in-reset and post-release state.
    task automatic pulse_reset(input string tag);
        @(negedge CLK);
        #2;
        RESET_N  = 1'b0;
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        #1;
        chk_reset_outputs({tag, ".in"});
        chk({tag, ".in.ird"}, {31'd0, IN_READY}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        chk_reset_outputs({tag, ".rel"});
        chk({tag, ".rel.ird"}, {31'd0, IN_READY}, 32'd1);
    endtask

    initial begin
        vec_t v;
        int   exp_stall;

        RESET_N   = 1'b1;
        FLUSH     = 1'b0;
        IN_VALID  = 1'b0;
        IN_CTRL   = 5'd0;
        IN_DATA   = 32'd0;
        OUT_READY = 1'b0;

        //                 flush iv    ictrl      idata     ordy | ird  ov    octrl data      occ   stall
        // Streaming with OUT_READY high: 1 beat/cycle, occupancy <= 1.
        vecs[0]  = '{1'b0, 1'b1, 5'b11000, 32'h1,  1'b1, 1'b1, 1'b1, 2'd3, 32'h1,  2'd1, 4'd0};
        vecs[1]  = '{1'b0, 1'b1, 5'b11000, 32'h2,  1'b1, 1'b1, 1'b1, 2'd3, 32'h2,  2'd1, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, 5'b11000, 32'h3,  1'b1, 1'b1, 1'b1, 2'd3, 32'h3,  2'd1, 4'd0};
        vecs[3]  = '{1'b0, 1'b0, 5'b00000, 32'h0,  1'b1, 1'b1, 1'b0, 2'd0, 32'h3,  2'd0, 4'd0};
        // Back-pressure: A held, B skidded, C pending, then drain in order.
        vecs[4]  = '{1'b0, 1'b1, 5'b01000, 32'hA,  1'b0, 1'b1, 1'b1, 2'd1, 32'hA,  2'd1, 4'd0};
        vecs[5]  = '{1'b0, 1'b1, 5'b10111, 32'hB,  1'b0, 1'b1, 1'b1, 2'd1, 32'hA,  2'd2, 4'd1};
        vecs[6]  = '{1'b0, 1'b1, 5'b11000, 32'hC,  1'b0, 1'b0, 1'b1, 2'd1, 32'hA,  2'd2, 4'd2};
        vecs[7]  = '{1'b0, 1'b1, 5'b11000, 32'hC,  1'b0, 1'b0, 1'b1, 2'd1, 32'hA,  2'd2, 4'd3};
        vecs[8]  = '{1'b0, 1'b1, 5'b11000, 32'hC,  1'b1, 1'b0, 1'b1, 2'd2, 32'hB,  2'd1, 4'd3};
        vecs[9]  = '{1'b0, 1'b1, 5'b11000, 32'hC,  1'b1, 1'b1, 1'b1, 2'd3, 32'hC,  2'd1, 4'd3};
        vecs[10] = '{1'b0, 1'b0, 5'b00000, 32'h0,  1'b1, 1'b1, 1'b0, 2'd0, 32'hC,  2'd0, 4'd3};
        // Flush from a full stage with a beat offered; skidded beat must not reappear.
        vecs[11] = '{1'b0, 1'b1, 5'b11000, 32'h11, 1'b0, 1'b1, 1'b1, 2'd3, 32'h11, 2'd1, 4'd3};
        vecs[12] = '{1'b0, 1'b1, 5'b01000, 32'h22, 1'b0, 1'b1, 1'b1, 2'd3, 32'h11, 2'd2, 4'd4};
        vecs[13] = '{1'b1, 1'b1, 5'b11000, 32'h33, 1'b0, 1'b0, 1'b0, 2'd0, 32'h11, 2'd0, 4'd5};
        vecs[14] = '{1'b0, 1'b0, 5'b00000, 32'h0,  1'b0, 1'b1, 1'b0, 2'd0, 32'h11, 2'd0, 4'd5};
        vecs[15] = '{1'b0, 1'b1, 5'b10111, 32'h44, 1'b1, 1'b1, 1'b1, 2'd2, 32'h44, 2'd1, 4'd5};
        vecs[16] = '{1'b0, 1'b0, 5'b00000, 32'h0,  1'b1, 1'b1, 1'b0, 2'd0, 32'h44, 2'd0, 4'd5};
        // Flush coinciding with an emit from a single-entry stage.
        vecs[17] = '{1'b0, 1'b1, 5'b11000, 32'h55, 1'b0, 1'b1, 1'b1, 2'd3, 32'h55, 2'd1, 4'd5};
        vecs[18] = '{1'b1, 1'b0, 5'b00000, 32'h0,  1'b1, 1'b0, 1'b0, 2'd0, 32'h55, 2'd0, 4'd5};

        // Reset / idle.
        #2;
        RESET_N = 1'b0;
        #1;
        chk_reset_outputs("rst");
        chk("rst.ird", {31'd0, IN_READY}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        chk_reset_outputs("rel");
        chk("rel.ird", {31'd0, IN_READY}, 32'd1);

        for (int i = 0; i < 19; i++) begin
            step(vecs[i], $sformatf("v%0d", i));
        end

        // Counter saturation: hold one beat with OUT_READY low for 20 cycles.
        pulse_reset("rst2");
        v = '{1'b0, 1'b1, 5'b11000, 32'h77, 1'b0, 1'b1, 1'b1, 2'd3, 32'h77, 2'd1, 4'd0};
        step(v, "sat0");
        for (int k = 1; k <= 20; k++) begin
            exp_stall = (k > 15) ? 15 : k;
            v = '{1'b0, 1'b0, 5'b00000, 32'h0, 1'b0, 1'b1, 1'b1, 2'd3, 32'h77, 2'd1, exp_stall[3:0]};
            step(v, $sformatf("sat%0d", k));
        end

        // Fill the second entry, then reset asynchronously between edges.
        v = '{1'b0, 1'b1, 5'b01000, 32'h88, 1'b0, 1'b1, 1'b1, 2'd3, 32'h77, 2'd2, 4'd15};
        step(v, "full");
        #3;
        RESET_N  = 1'b0;
        IN_VALID = 1'b0;
        #1;
        chk_reset_outputs("arst");
        chk("arst.ird", {31'd0, IN_READY}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        chk_reset_outputs("arel");
        chk("arel.ird", {31'd0, IN_READY}, 32'd1);

        // After reset the discarded beats must not resurface.
        v = '{1'b0, 1'b1, 5'b10111, 32'h99, 1'b1, 1'b1, 1'b1, 2'd2, 32'h99, 2'd1, 4'd0};
        step(v, "post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised, elastic pipeline-stage register that generalises the fixed stage-boundary latches (such as MEM→WB) used between pipeline stages. Each side has a valid/ready handshake, backed by a 2-entry skid buffer, so back-pressure never creates a combinational path across the stage. The block selects and forwards a parametrised slice of the incoming control bundle, inserts bubbles on flush, and counts output stall cycles.

## Interface
Parameters:
- DATA_W, 32: payload width (ALU result, read data, RD, PC+4 etc. packed by the instantiating stage).
- CTRL_IN_W, 5: width of the incoming control bundle.
- CTRL_OUT_W, 2: width of the forwarded control field.
- CTRL_LSB, 3: LSB of the forwarded field in IN_CTRL. Elaboration error unless CTRL_LSB+CTRL_OUT_W ≤ CTRL_IN_W.
- CNT_W, 16: stall counter width.

Ports:
- CLK, input, 1: single clock, rising edge.
- RESET_N, input, 1: asynchronous, active-low reset.
- FLUSH, input, 1: synchronous flush; empties the stage.
- IN_VALID, input, 1: upstream beat valid.
- IN_READY, output, 1: stage can accept a beat this cycle.
- IN_CTRL, input, CTRL_IN_W: upstream control bundle.
- IN_DATA, input, DATA_W: upstream payload.
- OUT_VALID, output, 1: output beat valid.
- OUT_READY, input, 1: downstream accepts the beat.
- OUT_CTRL, output, CTRL_OUT_W: IN_CTRL[CTRL_LSB +: CTRL_OUT_W] of the head beat; all-zero (bubble) when OUT_VALID=0.
- OUT_DATA, output, DATA_W: payload of the head beat.
- OCCUPANCY, output, 2: number of held beats (0, 1 or 2).
- STALL_CNT, output, CNT_W: saturating count of cycles with OUT_VALID=1 and OUT_READY=0.

## Operation
- The stage has two entries: main, which drives OUT_*, and skid. Each entry stores the control slice and the payload.
- Accept = IN_VALID & IN_READY. Emit = OUT_VALID & OUT_READY.
- IN_READY = RESET_N & ~FLUSH & (OCCUPANCY != 2). It is decoded from registered state and FLUSH only.
- State machine on OCCUPANCY:
  - EMPTY(0): accept → ONE; main loads the input.
  - ONE(1):
    - accept & emit → ONE; main loads the input.
    - accept & ~emit → TWO; skid loads the input.
    - emit & ~accept → EMPTY.
    - neither → hold.
  - TWO(2): no accept is possible. Emit → ONE; main loads skid. No emit → hold.
- Ordering is strictly FIFO. No beat is duplicated or dropped except by FLUSH.
- FLUSH has priority over every other event:
  - Next state is EMPTY, OUT_VALID=0 and OUT_CTRL=0.
  - OUT_DATA holds its last value.
  - Any held beat is discarded. An emit in the same cycle still completes, because the downstream has already sampled the beat.
- OUT_CTRL is a registered value. It is cleared whenever the next state is EMPTY, so an empty stage always presents a no-write bubble.
- STALL_CNT increments when OUT_VALID & ~OUT_READY. It saturates at 2^CNT_W−1 and is cleared only by reset.
- Reset values: OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, skid contents=0, OCCUPANCY=0, STALL_CNT=0. IN_READY=0 while RESET_N=0 and 1 on the first cycle after release, unless FLUSH is asserted.

## Timing
- Latency: a beat accepted at edge N is presented on OUT_* after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle when OUT_READY is held high; occupancy stays at 1 or below.
- Skid behaviour: when OUT_READY falls, at most one further beat is absorbed. IN_READY drops in the cycle after the second entry fills.
- No combinational path exists IN_VALID→OUT_VALID, IN_DATA→OUT_DATA or OUT_READY→IN_READY. The only combinational input-to-output path is FLUSH/RESET_N→IN_READY.
- Reset asserted mid-operation clears all state asynchronously. In-flight beats are lost and no partial output is produced.
- IN_DATA and IN_CTRL are sampled only on accept. Their values are don't-care otherwise.

## Test plan
- Reset/idle:
  - Stimulus: RESET_N low, then released with IN_VALID=0.
  - Required: OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, OCCUPANCY=0, STALL_CNT=0; IN_READY=1 in the first cycle after release.
- Streaming:
  - Stimulus: OUT_READY=1; beats with data 0x1, 0x2, 0x3 and IN_CTRL=5'b11000 on consecutive cycles.
  - Required: outputs appear one cycle later in order, OUT_CTRL=2'b11, OCCUPANCY never exceeds 1.
- Back-pressure:
  - Stimulus: OUT_READY=0 while beats 0xA, 0xB, 0xC are offered.
  - Required: 0xA is held at the output and 0xB is skidded; IN_READY=0 while 0xC stays pending; STALL_CNT counts the stalled cycles.
  - Stimulus (continued): OUT_READY=1.
  - Required: output order 0xA, 0xB, 0xC with no loss.
- Flush:
  - Stimulus: OCCUPANCY=2, then FLUSH for 1 cycle with IN_VALID=1.
  - Required: next cycle OUT_VALID=0, OUT_CTRL=0, OCCUPANCY=0; the offered beat is not accepted (IN_READY=0 during FLUSH).
- Counter saturation:
  - Stimulus: CNT_W=4, OUT_VALID held with OUT_READY=0 for 20 cycles.
  - Required: STALL_CNT stops at 15.
- Async reset mid-stream:
  - Stimulus: RESET_N pulsed low between clock edges while OCCUPANCY=2.
  - Required: all outputs return to reset values immediately, without waiting for a CLK edge.
